div_seq_ctrl: RTL and testbench

- Iterative non-restoring divider for the EX stage. It sequences one XLEN-wide controlled add/subtract row, one row operation per cycle, instead of an unrolled CAS array.
- Implements RISC-V DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed-overflow results.
- Uses a start/busy handshake on the issue side and a valid/ready handshake on the writeback side. Supports flush on pipeline kill.

---
 rtl/div_pkg.sv | 19 +
 rtl/cas_row.sv | 25 ++
 rtl/div_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: op encodings, FSM states and width default.
package div_pkg;

    localparam int DIV_XLEN = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/cas_row.sv
// One row of controlled add/subtract cells, XLEN+1 bits wide with a ripple carry.
module cas_row #(
    parameter int XLEN = 32
) (
    input  logic            sub_en,
    input  logic [XLEN:0]   a,
    input  logic [XLEN:0]   b,
    output logic [XLEN:0]   sum
);

    logic [XLEN:0] bx;
    logic [XLEN:0] carry;

    // Subtraction is a + ~b + 1: invert b and inject sub_en as the carry-in.
    assign bx       = b ^ {(XLEN + 1){sub_en}};
    assign carry[0] = sub_en;

    for (genvar i = 0; i <= XLEN; i++) begin : g_cell
        assign sum[i] = a[i] ^ bx[i] ^ carry[i];
        if (i < XLEN) begin : g_carry
            assign carry[i + 1] = (a[i] & bx[i]) | (carry[i] & (a[i] ^ bx[i]));
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative non-restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One shared cas_row performs the per-cycle row operation and the final remainder fix-up.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN - 1){1'b0}}};

    div_state_t state, state_next;

    logic [1:0]      op_r;
    logic [XLEN-1:0] dvd_r;
    logic [XLEN-1:0] dvs_r;
    logic [XLEN:0]   r_r;
    logic [XLEN-1:0] q_r;
    logic [XLEN:0]   d_r;
    logic [CNT_W-1:0] cnt_r;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] result_r;

    logic            is_signed;
    logic            a_neg;
    logic            d_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] d_abs;
    logic            div_zero;
    logic            sig_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    logic            row_sub;
    logic [XLEN:0]   row_a;
    logic [XLEN:0]   row_sum;
    logic [XLEN-1:0] rem_mag;
    logic [XLEN-1:0] quo_val;
    logic [XLEN-1:0] rem_val;
    logic [XLEN-1:0] fix_res;

    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = result_r;

    // Operand conditioning and special-case detection, used in PREP.
    always_comb begin
        is_signed   = ~op_r[0];
        a_neg       = is_signed & dvd_r[XLEN-1];
        d_neg       = is_signed & dvs_r[XLEN-1];
        a_abs       = a_neg ? (~dvd_r + 1'b1) : dvd_r;
        d_abs       = d_neg ? (~dvs_r + 1'b1) : dvs_r;
        div_zero    = (dvs_r == '0);
        sig_ovf     = is_signed & (dvd_r == MIN_VAL) & (dvs_r == '1);
        special     = div_zero | sig_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = op_r[1] ? dvd_r : '1;
        end else if (sig_ovf) begin
            special_res = op_r[1] ? '0 : MIN_VAL;
        end
    end

    // ITER shifts {R,Q} into the row; FIX reuses the row as a plain add for the restore.
    always_comb begin
        row_a   = (state == ST_ITER) ? {r_r[XLEN-1:0], q_r[XLEN-1]} : r_r;
        row_sub = (state == ST_ITER) & ~r_r[XLEN];
    end

    cas_row #(.XLEN(XLEN)) u_row (
        .sub_en (row_sub),
        .a      (row_a),
        .b      (d_r),
        .sum    (row_sum)
    );

    always_comb begin
        rem_mag = r_r[XLEN] ? row_sum[XLEN-1:0] : r_r[XLEN-1:0];
        quo_val = neg_q ? (~q_r + 1'b1) : q_r;
        rem_val = neg_r ? (~rem_mag + 1'b1) : rem_mag;
        fix_res = op_r[1] ? rem_val : quo_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_next = ST_PREP;
                ST_PREP: state_next = special ? ST_DONE : ST_ITER;
                ST_ITER: if (cnt_r == CNT_W'(1)) state_next = ST_FIX;
                ST_FIX:  state_next = ST_DONE;
                ST_DONE: if (out_ready) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= '0;
            dvd_r    <= '0;
            dvs_r    <= '0;
            r_r      <= '0;
            q_r      <= '0;
            d_r      <= '0;
            cnt_r    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_r <= '0;
        end else if (!flush) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        dvd_r <= dividend;
                        dvs_r <= divisor;
                    end
                end
                ST_PREP: begin
                    r_r   <= '0;
                    q_r   <= a_abs;
                    d_r   <= {1'b0, d_abs};
                    cnt_r <= CNT_W'(XLEN);
                    neg_q <= a_neg ^ d_neg;
                    neg_r <= a_neg;
                    if (special) result_r <= special_res;
                end
                ST_ITER: begin
                    r_r   <= row_sum;
                    q_r   <= {q_r[XLEN-2:0], ~row_sum[XLEN]};
                    cnt_r <= cnt_r - 1'b1;
                end
                ST_FIX: begin
                    result_r <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed table, hand-written corner sequences, random vs. model.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference semantics from the RISC-V rules using plain integer arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            2'b00:   return ovf ? 32'h8000_0000 : 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return ovf ? 32'h0 : 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 2;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Called #1 after an edge with the DUT idle; that cycle is cycle 0. Returns at the first
    // cycle with out_valid=1 (without consuming) and the cycle number in lat.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("timeout_valid", 32'(lat), 32'(0));
        res = result;
    endtask

    task automatic run_and_check(input string name, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] r;
        int          l;
        out_ready = 1'b1;
        launch(o, a, b, r, l);
        check({name, "_result"}, r, exp_res);
        check({name, "_latency"}, 32'(l), 32'(exp_lat));
        @(posedge clk); #1;
        check({name, "_idle_after"}, {31'b0, busy}, 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] r;
        int          l;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0] = '{"divu_100_7",  2'b01, 32'd100,        32'd7,          32'd14,         35};
        vecs[1] = '{"remu_100_7",  2'b11, 32'd100,        32'd7,          32'd2,          35};
        vecs[2] = '{"div_m7_2",    2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35};
        vecs[3] = '{"rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35};
        vecs[4] = '{"div_7_m2",    2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35};
        vecs[5] = '{"divu_5_0",    2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
        vecs[6] = '{"rem_5_0",     2'b10, 32'd5,          32'd0,          32'd5,          2};
        vecs[7] = '{"div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
        vecs[8] = '{"rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          2};

        rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
        end

        // busy rises the cycle after acceptance.
        start = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd5;
        check("busy_cycle0", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_cycle1", {31'b0, busy}, 32'd1);
        // Flush at cycle 10 of this DIVU.
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        run_and_check("post_flush_divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 35);

        // flush together with start in IDLE drops the start.
        flush = 1'b1; start = 1'b1; op = 2'b01; dividend = 32'd8; divisor = 32'd2;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check("flush_start_dropped", {31'b0, busy}, 32'd0);

        // Backpressure: hold out_ready low for 5 cycles, pulse start meanwhile.
        out_ready = 1'b0;
        launch(2'b01, 32'd1000, 32'd10, r, l);
        check("bp_result", r, 32'd100);
        for (int k = 0; k < 5; k++) begin
            start = 1'b1; op = 2'b01; dividend = 32'd77; divisor = 32'd1;
            @(posedge clk); #1;
            check("bp_valid_held", {31'b0, out_valid}, 32'd1);
            check("bp_busy_held", {31'b0, busy}, 32'd1);
            check("bp_result_held", result, 32'd100);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", {30'b0, busy, out_valid}, 32'd0);
        run_and_check("bp_next_divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 35);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 16));
                3: rb = -32'($urandom_range(1, 16));
                default: ;
            endcase
            run_and_check("rand", ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
